// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the CPU core and a word-wide,
// byte-addressed memory port. It takes one byte/half/word access at a time
// and issues word-aligned reads or strobed writes. An access that straddles
// a word boundary becomes two aligned accesses, and load data is realigned
// and sign- or zero-extended before it is returned.
//
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to reject
// word-crossing requests with an error response instead of splitting them.
//
// Ports:
//   iwClk, iwRst                     clock, asynchronous active-high reset
//   iwReqValid/owReqReady            request handshake (ready while idle)
//   iwReqWrite, iwReqSize,
//   iwReqSigned, iwReqAddr,
//   iwReqWData                       request payload
//   orRspValid, orRspData, orRspErr  one-cycle completion pulse + result
//   orMemReadAddr, iwMemReadData     read port (data is sampled one cycle
//                                    after the address is driven)
//   orMemWriteAddr, orMemWriteData,
//   orMemWstrb                       write port (strobes nonzero one cycle)
module mem_access_unit #(
  parameter int unsigned pAddrWidth = 32
) (
  input  logic                  iwClk,
  input  logic                  iwRst,
  input  logic                  iwReqValid,
  output logic                  owReqReady,
  input  logic                  iwReqWrite,
  input  logic [1:0]            iwReqSize,
  input  logic                  iwReqSigned,
  input  logic [pAddrWidth-1:0] iwReqAddr,
  input  logic [31:0]           iwReqWData,
  output logic                  orRspValid,
  output logic [31:0]           orRspData,
  output logic                  orRspErr,
  output logic [pAddrWidth-1:0] orMemReadAddr,
  input  logic [31:0]           iwMemReadData,
  output logic [pAddrWidth-1:0] orMemWriteAddr,
  output logic [31:0]           orMemWriteData,
  output logic [3:0]            orMemWstrb
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD1  = 3'd1;
  localparam logic [2:0] RD2  = 3'd2;
  localparam logic [2:0] WR1  = 3'd3;
  localparam logic [2:0] WR2  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [pAddrWidth-1:0] rd_addr_q, rd_addr_d;
  logic [pAddrWidth-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [3:0]            wstrb_hi_q, wstrb_hi_d;
  logic [pAddrWidth-1:0] base_q, base_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic                  cross_q, cross_d;
  logic [31:0]           lo_q, lo_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  // Request decode: aligned base, byte offset, lane mask, rotated data.
  logic [pAddrWidth-1:0] req_base;
  logic [1:0]            req_off;
  logic [2:0]            req_n;
  logic                  req_cross;
  logic [7:0]            req_mask;
  logic [63:0]           req_dbl;
  logic [31:0]           req_rot;
  logic                  trap_c;

  always_comb begin
    req_base = {iwReqAddr[pAddrWidth-1:2], 2'b00};
    req_off  = iwReqAddr[1:0];
    case (iwReqSize)
      2'd0:    begin req_n = 3'd1; req_mask = 8'b0000_0001; end
      2'd1:    begin req_n = 3'd2; req_mask = 8'b0000_0011; end
      default: begin req_n = 3'd4; req_mask = 8'b0000_1111; end
    endcase
    req_mask  = req_mask << req_off;
    req_cross = (3'({1'b0, req_off}) + req_n) > 3'd4;
    // Upper half of the doubled word shifted left is a rotate-left.
    req_dbl   = {iwReqWData, iwReqWData} << {req_off, 3'b000};
    req_rot   = req_dbl[63:32];
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    trap_c    = req_cross;
`else
    trap_c    = 1'b0;
`endif
  end

  // Realign {hi,lo} by the byte offset and extend to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] lo, input logic [31:0] hi,
                                          input logic [1:0] off, input logic [1:0] size,
                                          input logic sgn);
    logic [31:0] sh;
    sh = 32'({hi, lo} >> {off, 3'b000});
    case (size)
      2'd0:    extract = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    extract = {{16{sgn & sh[15]}}, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  // In RD1 the low word is still on the bus; in RD2 it comes from lo_q.
  logic [31:0] ext_lo_c, ext_data_c;
  always_comb begin
    ext_lo_c   = (state_q == RD2) ? lo_q : iwMemReadData;
    ext_data_c = extract(ext_lo_c, iwMemReadData, off_q, size_q, sgn_q);
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wstrb_d     = wstrb_q;
    wstrb_hi_d  = wstrb_hi_q;
    base_d      = base_q;
    off_d       = off_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    cross_d     = cross_q;
    lo_d        = lo_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (iwReqValid) begin
          base_d     = req_base;
          off_d      = req_off;
          size_d     = iwReqSize;
          sgn_d      = iwReqSigned;
          cross_d    = req_cross;
          wstrb_hi_d = req_mask[7:4];
          if (trap_c) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 32'd0;
          end else if (iwReqWrite) begin
            wr_addr_d = req_base;
            wstrb_d   = req_mask[3:0];
            wr_data_d = req_rot;
            state_d   = WR1;
          end else begin
            rd_addr_d = req_base;
            state_d   = RD1;
          end
        end
      end
      RD1: begin
        lo_d = iwMemReadData;
        if (cross_q) begin
          rd_addr_d = base_q + pAddrWidth'(4);
          state_d   = RD2;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = ext_data_c;
          state_d     = IDLE;
        end
      end
      RD2: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = ext_data_c;
        state_d     = IDLE;
      end
      WR1: begin
        if (cross_q) begin
          wr_addr_d = base_q + pAddrWidth'(4);
          wstrb_d   = wstrb_hi_q;
          state_d   = WR2;
        end else begin
          wstrb_d     = 4'd0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'd0;
          state_d     = IDLE;
        end
      end
      WR2: begin
        wstrb_d     = 4'd0;
        rsp_valid_d = 1'b1;
        rsp_data_d  = 32'd0;
        state_d     = IDLE;
      end
      default: begin
        wstrb_d = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wstrb_q     <= '0;
      wstrb_hi_q  <= '0;
      base_q      <= '0;
      off_q       <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      cross_q     <= 1'b0;
      lo_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wstrb_q     <= wstrb_d;
      wstrb_hi_q  <= wstrb_hi_d;
      base_q      <= base_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      cross_q     <= cross_d;
      lo_q        <= lo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign owReqReady     = (state_q == IDLE);
  assign orRspValid     = rsp_valid_q;
  assign orRspData      = rsp_data_q;
  assign orRspErr       = rsp_err_q;
  assign orMemReadAddr  = rd_addr_q;
  assign orMemWriteAddr = wr_addr_q;
  assign orMemWriteData = wr_data_q;
  assign orMemWstrb     = wstrb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of directed requests with hand-computed
// results against a 16-word memory model, plus reset sequences.
module tb_mem_access_unit;

  logic        iwClk;
  logic        iwRst;
  logic        iwReqValid;
  logic        owReqReady;
  logic        iwReqWrite;
  logic [1:0]  iwReqSize;
  logic        iwReqSigned;
  logic [31:0] iwReqAddr;
  logic [31:0] iwReqWData;
  logic        orRspValid;
  logic [31:0] orRspData;
  logic        orRspErr;
  logic [31:0] orMemReadAddr;
  logic [31:0] iwMemReadData;
  logic [31:0] orMemWriteAddr;
  logic [31:0] orMemWriteData;
  logic [3:0]  orMemWstrb;

  mem_access_unit #(.pAddrWidth(32)) dut (
    .iwClk(iwClk), .iwRst(iwRst),
    .iwReqValid(iwReqValid), .owReqReady(owReqReady),
    .iwReqWrite(iwReqWrite), .iwReqSize(iwReqSize),
    .iwReqSigned(iwReqSigned), .iwReqAddr(iwReqAddr),
    .iwReqWData(iwReqWData),
    .orRspValid(orRspValid), .orRspData(orRspData), .orRspErr(orRspErr),
    .orMemReadAddr(orMemReadAddr), .iwMemReadData(iwMemReadData),
    .orMemWriteAddr(orMemWriteAddr), .orMemWriteData(orMemWriteData),
    .orMemWstrb(orMemWstrb)
  );

  always #5 iwClk = ~iwClk;

  // Memory model: 16 words, address bits [5:2] select the word.
  logic [31:0] mem [16];
  assign iwMemReadData = mem[orMemReadAddr[5:2]];
  always @(posedge iwClk) begin
    for (int b = 0; b < 4; b++)
      if (orMemWstrb[b]) mem[orMemWriteAddr[5:2]][8*b +: 8] <= orMemWriteData[8*b +: 8];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          lat;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs [18];

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge iwClk);
    chk($sformatf("v%0d_ready", idx), 32'(owReqReady), 32'd1);
    iwReqWrite  = v.wr;
    iwReqSize   = v.size;
    iwReqSigned = v.sgn;
    iwReqAddr   = v.addr;
    iwReqWData  = v.wdata;
    iwReqValid  = 1'b1;
    @(posedge iwClk); #1;
    iwReqValid = 1'b0;
    chk($sformatf("v%0d_rspv_c1", idx), 32'(orRspValid), 32'd0);
    if (v.wr) begin
      chk($sformatf("v%0d_waddr0", idx), orMemWriteAddr, v.a0);
      chk($sformatf("v%0d_wstrb0", idx), 32'(orMemWstrb), 32'(v.s0));
      chk($sformatf("v%0d_wdata0", idx), orMemWriteData, v.wd);
    end else begin
      chk($sformatf("v%0d_raddr0", idx), orMemReadAddr, v.a0);
    end
    if (v.lat == 3) begin
      @(posedge iwClk); #1;
      chk($sformatf("v%0d_rspv_c2", idx), 32'(orRspValid), 32'd0);
      if (v.wr) begin
        chk($sformatf("v%0d_waddr1", idx), orMemWriteAddr, v.a1);
        chk($sformatf("v%0d_wstrb1", idx), 32'(orMemWstrb), 32'(v.s1));
        chk($sformatf("v%0d_wdata1", idx), orMemWriteData, v.wd);
      end else begin
        chk($sformatf("v%0d_raddr1", idx), orMemReadAddr, v.a1);
      end
    end
    @(posedge iwClk); #1;
    chk($sformatf("v%0d_rspv", idx), 32'(orRspValid), 32'd1);
    chk($sformatf("v%0d_rdata", idx), orRspData, v.exp_data);
    chk($sformatf("v%0d_rerr", idx), 32'(orRspErr), 32'd0);
    chk($sformatf("v%0d_wstrb_end", idx), 32'(orMemWstrb), 32'd0);
  endtask

  initial begin
    //            wr    sz    sg    addr          wdata         exp_data      lat a0            s0       a1            s1       wd
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        2, 32'h10,       4'b1111, 32'h0,        4'b0000, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 2, 32'h10,       4'b0000, 32'h0,        4'b0000, 32'h0};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h23,       32'h0,        32'hFFFFFF80, 2, 32'h20,       4'b0000, 32'h0,        4'b0000, 32'h0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h23,       32'h0,        32'h00000080, 2, 32'h20,       4'b0000, 32'h0,        4'b0000, 32'h0};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h22,       32'h0,        32'hFFFF80FF, 2, 32'h20,       4'b0000, 32'h0,        4'b0000, 32'h0};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h21,       32'h0,        32'hFFFFFF12, 2, 32'h20,       4'b0000, 32'h0,        4'b0000, 32'h0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h20,       32'h0,        32'h00001234, 2, 32'h20,       4'b0000, 32'h0,        4'b0000, 32'h0};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h0B,       32'h0000ABCD, 32'h0,        3, 32'h08,       4'b1000, 32'h0C,       4'b0001, 32'hCD0000AB};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h06,       32'h0,        32'h55443322, 3, 32'h04,       4'b0000, 32'h08,       4'b0000, 32'h0};
    vecs[9]  = '{1'b0, 2'd1, 1'b1, 32'h0B,       32'h0,        32'hFFFFABCD, 3, 32'h08,       4'b0000, 32'h0C,       4'b0000, 32'h0};
    vecs[10] = '{1'b1, 2'd0, 1'b0, 32'h31,       32'h123456A5, 32'h0,        2, 32'h30,       4'b0010, 32'h0,        4'b0000, 32'h3456A512};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h30,       32'h0,        32'h0000A500, 2, 32'h30,       4'b0000, 32'h0,        4'b0000, 32'h0};
    vecs[12] = '{1'b1, 2'd3, 1'b0, 32'h2D,       32'h11223344, 32'h0,        3, 32'h2C,       4'b1110, 32'h30,       4'b0001, 32'h22334411};
    vecs[13] = '{1'b0, 2'd3, 1'b0, 32'h2D,       32'h0,        32'h11223344, 3, 32'h2C,       4'b0000, 32'h30,       4'b0000, 32'h0};
    vecs[14] = '{1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0000BEEF, 32'h0,        3, 32'hFFFFFFFC, 4'b1000, 32'h00000000, 4'b0001, 32'hEF0000BE};
    vecs[15] = '{1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h0000BEEF, 3, 32'hFFFFFFFC, 4'b0000, 32'h00000000, 4'b0000, 32'h0};
    // After the interrupted split store: first half landed, second did not.
    vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h08,       32'h0,        32'h34665544, 2, 32'h08,       4'b0000, 32'h0,        4'b0000, 32'h0};
    vecs[17] = '{1'b0, 2'd2, 1'b0, 32'h0C,       32'h0,        32'h000000AB, 2, 32'h0C,       4'b0000, 32'h0,        4'b0000, 32'h0};

    for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    mem[1] <= 32'h33221100;
    mem[2] <= 32'h77665544;
    mem[8] <= 32'h80FF1234;

    iwClk = 1'b0; iwRst = 1'b1; iwReqValid = 1'b0; iwReqWrite = 1'b0;
    iwReqSize = 2'd0; iwReqSigned = 1'b0; iwReqAddr = 32'h0; iwReqWData = 32'h0;

    repeat (3) @(posedge iwClk);
    @(negedge iwClk);
    chk("rst_rspv",  32'(orRspValid), 32'd0);
    chk("rst_rdata", orRspData, 32'd0);
    chk("rst_rerr",  32'(orRspErr), 32'd0);
    chk("rst_raddr", orMemReadAddr, 32'd0);
    chk("rst_waddr", orMemWriteAddr, 32'd0);
    chk("rst_wdata", orMemWriteData, 32'd0);
    chk("rst_wstrb", 32'(orMemWstrb), 32'd0);
    iwRst = 1'b0;
    #1;
    chk("rst_ready", 32'(owReqReady), 32'd1);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Reset while the second half of a split store is on the bus.
    @(negedge iwClk);
    iwReqWrite = 1'b1; iwReqSize = 2'd1; iwReqSigned = 1'b0;
    iwReqAddr = 32'h0B; iwReqWData = 32'h00001234; iwReqValid = 1'b1;
    @(posedge iwClk); #1;
    iwReqValid = 1'b0;
    chk("mr_wstrb_wr1", 32'(orMemWstrb), 32'b1000);
    chk("mr_wdata_wr1", orMemWriteData, 32'h34000012);
    @(posedge iwClk); #1;
    chk("mr_wstrb_wr2", 32'(orMemWstrb), 32'b0001);
    #2;
    iwRst = 1'b1;
    #1;
    chk("mr_wstrb_async", 32'(orMemWstrb), 32'd0);
    chk("mr_rspv_async",  32'(orRspValid), 32'd0);
    @(posedge iwClk); #1;
    chk("mr_rspv_hold", 32'(orRspValid), 32'd0);
    @(negedge iwClk);
    iwRst = 1'b0;
    #1;
    chk("mr_ready", 32'(owReqReady), 32'd1);
    @(posedge iwClk); #1;
    chk("mr_rspv_after", 32'(orRspValid), 32'd0);
    chk("mr_wstrb_after", 32'(orMemWstrb), 32'd0);

    for (int i = 16; i < 18; i++) run_vec(vecs[i], i);

    repeat (2) @(posedge iwClk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
